// File: rtl/perf_counter_reporter.sv
// Snapshots five 32-bit performance counters and streams them as a 22-byte frame
// (header, 20 little-endian payload bytes, XOR checksum) over a byte valid/ready link.
module perf_counter_reporter #(
   parameter logic [7:0]  HEADER_BYTE = 8'hA5,
   parameter int unsigned AUTO_PERIOD = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cycle_count,
   input  logic [31:0] instruction_count,
   input  logic [31:0] stall_count,
   input  logic [31:0] branch_count,
   input  logic [31:0] branch_mispredicts,
   input  logic        snapshot_req,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        req_dropped
);

   localparam int unsigned NUM_BYTES = 20;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned CNT_W     = 32;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BYTES - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = (AUTO_PERIOD == 0) ? '0 : CNT_W'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;

   state_t                      state, state_nxt;
   logic [NUM_BYTES-1:0][7:0]   snap;
   logic [IDX_W-1:0]            idx, idx_d, idx_inc;
   logic [7:0]                  csum, csum_d;
   logic [CNT_W-1:0]            period_cnt, period_cnt_d;
   logic                        auto_pending, auto_pending_d;
   logic [7:0]                  tx_data_d;
   logic                        tx_valid_d, busy_d, frame_done_d, req_dropped_d;
   logic                        snap_load, auto_clear;
   logic                        hs, req, wrap;

   assign hs      = tx_valid & tx_ready;
   assign req     = snapshot_req | auto_pending;
   assign idx_inc = idx + IDX_W'(1);
   assign wrap    = (AUTO_PERIOD != 0) && (period_cnt == PERIOD_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (req)                    state_nxt = HEADER;
         HEADER:   if (hs)                     state_nxt = PAYLOAD;
         PAYLOAD:  if (hs && idx == LAST_IDX)  state_nxt = CHECKSUM;
         CHECKSUM: if (hs)                     state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath
   always_comb begin
      tx_data_d      = tx_data;
      tx_valid_d     = tx_valid;
      idx_d          = idx;
      csum_d         = csum;
      snap_load      = 1'b0;
      auto_clear     = 1'b0;
      frame_done_d   = 1'b0;
      req_dropped_d  = snapshot_req && (state != IDLE);
      case (state)
         IDLE: begin
            tx_valid_d = 1'b0;
            if (req) begin
               snap_load  = 1'b1;
               auto_clear = 1'b1;
               csum_d     = '0;
               idx_d      = '0;
               tx_valid_d = 1'b1;
               tx_data_d  = HEADER_BYTE;
            end
         end
         HEADER: begin
            if (hs) begin
               idx_d     = '0;
               tx_data_d = snap[0];
            end
         end
         PAYLOAD: begin
            if (hs) begin
               csum_d = csum ^ tx_data;
               idx_d  = idx_inc;
               // Last payload byte: present the checksum including the byte just sent
               if (idx == LAST_IDX) tx_data_d = csum ^ tx_data;
               else                 tx_data_d = snap[idx_inc];
            end
         end
         CHECKSUM: begin
            if (hs) begin
               tx_valid_d   = 1'b0;
               tx_data_d    = '0;
               frame_done_d = 1'b1;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
         end
      endcase
      busy_d = (state_nxt != IDLE);

      // Free-running period counter; a wrap wins over consumption so it is never lost
      if (AUTO_PERIOD == 0) begin
         period_cnt_d   = '0;
         auto_pending_d = 1'b0;
      end else begin
         period_cnt_d   = wrap ? '0 : period_cnt + CNT_W'(1);
         auto_pending_d = wrap | (auto_pending & ~auto_clear);
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap         <= '0;
         idx          <= '0;
         csum         <= '0;
         period_cnt   <= '0;
         auto_pending <= 1'b0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         req_dropped  <= 1'b0;
      end else begin
         if (snap_load)
            snap <= {branch_mispredicts, branch_count, stall_count, instruction_count, cycle_count};
         idx          <= idx_d;
         csum         <= csum_d;
         period_cnt   <= period_cnt_d;
         auto_pending <= auto_pending_d;
         tx_data      <= tx_data_d;
         tx_valid     <= tx_valid_d;
         busy         <= busy_d;
         frame_done   <= frame_done_d;
         req_dropped  <= req_dropped_d;
      end
   end

endmodule

// File: tb/tb_perf_counter_reporter.sv
// Bench for perf_counter_reporter: directed frames with random data/backpressure,
// checked against a frame model built from the captured counter values.
module tb_perf_counter_reporter;

   localparam logic [7:0] HDR = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n, a_rst_n;
   logic [31:0] c0, c1, c2, c3, c4;
   logic        snapshot_req, tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, frame_done, req_dropped;
   logic        a_req, a_ready;
   logic [7:0]  a_data;
   logic        a_valid, a_busy, a_done, a_dropped;

   int total = 0;
   int bad   = 0;
   logic [31:0] snapv [5];
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_q  [$];
   int          drops;

   always #5 clk = ~clk;

   perf_counter_reporter #(.HEADER_BYTE(HDR), .AUTO_PERIOD(0)) dut (
      .clk(clk), .reset_n(rst_n),
      .cycle_count(c0), .instruction_count(c1), .stall_count(c2),
      .branch_count(c3), .branch_mispredicts(c4),
      .snapshot_req(snapshot_req), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
      .req_dropped(req_dropped)
   );

   perf_counter_reporter #(.HEADER_BYTE(HDR), .AUTO_PERIOD(30)) dut_auto (
      .clk(clk), .reset_n(a_rst_n),
      .cycle_count(c0), .instruction_count(c1), .stall_count(c2),
      .branch_count(c3), .branch_mispredicts(c4),
      .snapshot_req(a_req), .tx_data(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .busy(a_busy), .frame_done(a_done),
      .req_dropped(a_dropped)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame model: header, each counter little-endian, XOR of the payload bytes
   task automatic build_exp();
      logic [7:0]  x, b;
      logic [31:0] v;
      exp_q.delete();
      exp_q.push_back(HDR);
      x = 8'h00;
      for (int i = 0; i < 5; i++) begin
         v = snapv[i];
         for (int k = 0; k < 4; k++) begin
            b = v[8*k +: 8];
            exp_q.push_back(b);
            x = x ^ b;
         end
      end
      exp_q.push_back(x);
   endtask

   task automatic send_req();
      @(negedge clk);
      c0 = snapv[0]; c1 = snapv[1]; c2 = snapv[2]; c3 = snapv[3]; c4 = snapv[4];
      snapshot_req = 1'b1;
      build_exp();
   endtask

   task automatic compare_frame(input string tag);
      chk({tag, "_len"}, 32'(rx_q.size()), 32'd22);
      for (int i = 0; i < 22 && i < rx_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
   endtask

   task automatic collect(input bit rnd, input int hold_at, input bit churn, input int drop_at);
      int   cyc = 0;
      int   hold_left = 5;
      bit   ps = 1'b0;
      bit   sent = 1'b0;
      bit   r;
      logic [7:0] pd = 8'h00;
      rx_q.delete();
      drops = 0;
      while (rx_q.size() < 22 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         snapshot_req = 1'b0;
         if (cyc == 1) begin
            chk("latency_valid", 32'(tx_valid), 32'd1);
            chk("latency_hdr", 32'(tx_data), 32'(HDR));
         end
         if (req_dropped) drops++;
         chk("busy_in_frame", 32'(busy), 32'd1);
         if (ps) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(pd));
         end
         if (churn) begin
            c0 = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom; c4 = $urandom;
         end
         if (hold_at >= 0 && rx_q.size() == hold_at && hold_left > 0) begin
            r = 1'b0;
            hold_left--;
         end else begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (drop_at >= 0 && rx_q.size() == drop_at && !sent) begin
            snapshot_req = 1'b1;
            sent = 1'b1;
         end
         tx_ready = r;
         if (tx_valid && r) rx_q.push_back(tx_data);
         ps = tx_valid && !r;
         pd = tx_data;
      end
      chk("frame_timeout", 32'(rx_q.size()), 32'd22);
      @(negedge clk);
      snapshot_req = 1'b0;
      tx_ready = 1'b0;
      if (req_dropped) drops++;
      chk("done_pulse", 32'(frame_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_valid", 32'(tx_valid), 32'd0);
      @(negedge clk);
      chk("done_once", 32'(frame_done), 32'd0);
   endtask

   int st[$], en[$];
   int acyc, cnt;
   bit pv;

   task automatic auto_watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         acyc++;
         if (a_valid && !pv) st.push_back(acyc);
         if (!a_valid && pv) en.push_back(acyc);
         pv = a_valid;
      end
   endtask

   initial begin
      rst_n = 1'b0; a_rst_n = 1'b0;
      snapshot_req = 1'b0; tx_ready = 1'b0; a_req = 1'b0; a_ready = 1'b1;
      c0 = '0; c1 = '0; c2 = '0; c3 = '0; c4 = '0;
      acyc = 0; pv = 1'b0;
      #12;
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_drop", 32'(req_dropped), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; a_rst_n = 1'b1;

      // Auto mode: frames every 30 cycles, then a long stall collapses wraps into one frame
      cnt = 0;
      while (st.size() < 4 && cnt < 400) begin auto_watch(1); cnt++; end
      chk("auto_start_timeout", 32'(st.size()), 32'd4);
      chk("auto_period_1", 32'(st[1] - st[0]), 32'd30);
      chk("auto_period_2", 32'(st[2] - st[1]), 32'd30);
      chk("auto_period_3", 32'(st[3] - st[2]), 32'd30);
      a_ready = 1'b0;
      auto_watch(100);
      chk("auto_stall_hold", 32'(a_valid), 32'd1);
      a_ready = 1'b1;
      auto_watch(150);
      chk("auto_starts", 32'(st.size() >= 6), 32'd1);
      chk("auto_ends", 32'(en.size() >= 5), 32'd1);
      chk("auto_pending_gap", 32'(st[4] - en[3]), 32'd1);
      chk("auto_single_pending", 32'((st[5] - en[4]) > 1), 32'd1);
      chk("idle_no_auto", 32'(tx_valid), 32'd0);

      // Basic frame
      snapv[0] = 32'h10; snapv[1] = 32'h0C; snapv[2] = 32'h02; snapv[3] = 32'h03; snapv[4] = 32'h01;
      send_req();
      collect(1'b0, -1, 1'b0, -1);
      compare_frame("basic");
      chk("basic_csum", 32'(rx_q[21]), 32'h1C);
      chk("basic_nodrop", 32'(drops), 32'd0);

      // Backpressure with random ready and a 5-cycle hold mid-payload
      send_req();
      collect(1'b1, 8, 1'b0, -1);
      compare_frame("bp");

      // Coherence: inputs churn every cycle during the frame
      for (int i = 0; i < 5; i++) snapv[i] = 32'hFFFF_FFFF;
      send_req();
      collect(1'b1, -1, 1'b1, -1);
      compare_frame("coh");
      chk("coh_csum", 32'(rx_q[21]), 32'h00);

      // Request during a frame is dropped and reported once
      for (int i = 0; i < 5; i++) snapv[i] = $urandom;
      send_req();
      collect(1'b0, -1, 1'b0, 5);
      compare_frame("drop");
      chk("drop_pulses", 32'(drops), 32'd1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_valid || req_dropped) cnt++;
      end
      chk("drop_no_extra_frame", 32'(cnt), 32'd0);

      // Random counters and backpressure
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 5; i++) snapv[i] = $urandom;
         send_req();
         collect(1'b1, -1, 1'b0, -1);
         compare_frame($sformatf("rnd%0d", k));
      end

      // Reset mid-frame, then a clean frame
      for (int i = 0; i < 5; i++) snapv[i] = $urandom;
      send_req();
      rx_q.delete();
      cnt = 0;
      while (cnt < 60) begin
         @(negedge clk);
         snapshot_req = 1'b0;
         cnt++;
         if (rx_q.size() == 11) break;
         tx_ready = 1'b1;
         if (tx_valid) rx_q.push_back(tx_data);
      end
      chk("mid_reached", 32'(rx_q.size()), 32'd11);
      rst_n = 1'b0;
      tx_ready = 1'b0;
      #1;
      chk("mid_rst_data", 32'(tx_data), 32'd0);
      chk("mid_rst_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'(tx_valid), 32'd0);
      for (int i = 0; i < 5; i++) snapv[i] = $urandom;
      send_req();
      collect(1'b1, -1, 1'b0, -1);
      compare_frame("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
